// File: rtl/sequenciador_quadros_pkg.sv
// Shared definitions for the OLED frame sequencer: pet-state codes, animation
// lengths per state, image size and the sequencer FSM encoding.
package seq_pkg;

  localparam logic [3:0] EST_IDLE       = 4'b0000;
  localparam logic [3:0] EST_DORMINDO   = 4'b0001;
  localparam logic [3:0] EST_COMENDO    = 4'b0010;
  localparam logic [3:0] EST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] EST_MORTO      = 4'b1000;

  localparam logic [3:0] NQ_IDLE       = 4'd6;
  localparam logic [3:0] NQ_DORMINDO   = 4'd4;
  localparam logic [3:0] NQ_COMENDO    = 4'd5;
  localparam logic [3:0] NQ_DANDO_AULA = 4'd7;
  localparam logic [3:0] NQ_MORTO      = 4'd8;

  localparam int         IMG_BYTES = 1024;
  localparam logic [9:0] LAST_BYTE = 10'(IMG_BYTES - 1);

  typedef enum logic [1:0] {
    ESPERA,
    BUSCA,
    ENVIA,
    FIM
  } seq_state_e;

  // Anything that is not a known one-hot code animates like IDLE.
  function automatic logic [3:0] n_quadros(input logic [3:0] estado);
    case (estado)
      EST_DORMINDO:   n_quadros = NQ_DORMINDO;
      EST_COMENDO:    n_quadros = NQ_COMENDO;
      EST_DANDO_AULA: n_quadros = NQ_DANDO_AULA;
      EST_MORTO:      n_quadros = NQ_MORTO;
      default:        n_quadros = NQ_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_quadros_divisor_tick.sv
// Refresh pacing counter: free-running 0..TICK_DIV-1 with a one-cycle tick
// while the counter sits on its last value.
module divisor_tick
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/sequenciador_quadros.sv
// Frame sequencer for the 128x64 OLED: paces refreshes, streams 1024 byte
// addresses with a tx handshake and steps the animation frame at frame end.
// Optional build macro SEQ_PINGPONG_EN makes the animation bounce instead of wrap.
module sequenciador_quadros
  import seq_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int ANIM_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] estado_in,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [9:0] byte_counter,
  output logic [3:0] estado_out,
  output logic [2:0] frame_idx,
  output logic       frame_done,
  output logic       busy
);

  localparam int            AW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

  logic          tick;
  seq_state_e    state_q;
  logic          pending_q;
  logic          txValid_q;
  logic [9:0]    byteCnt_q;
  logic [3:0]    estOut_q;
  logic [2:0]    frameIdx_q, frameIdx_d;
  logic [AW-1:0] animCnt_q, animCnt_d;
  logic          frameDone_q;
  logic          busy_q;
  logic [3:0]    nq;
  logic [2:0]    lastIdx;
`ifdef SEQ_PINGPONG_EN
  logic          dirDown_q, dirDown_d;
`endif

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Animation step applied at the end of each displayed frame.
  always_comb begin
    nq         = n_quadros(estOut_q);
    lastIdx    = 3'(nq - 4'd1);
    animCnt_d  = animCnt_q + AW'(1);
    frameIdx_d = frameIdx_q;
`ifdef SEQ_PINGPONG_EN
    dirDown_d  = dirDown_q;
`endif
    if (animCnt_q == ANIM_LAST) begin
      animCnt_d = '0;
`ifdef SEQ_PINGPONG_EN
      if (lastIdx == 3'd0) begin
        frameIdx_d = 3'd0;
      end else if (!dirDown_q) begin
        if (frameIdx_q >= lastIdx) begin
          dirDown_d  = 1'b1;
          frameIdx_d = lastIdx - 3'd1;
        end else begin
          frameIdx_d = frameIdx_q + 3'd1;
        end
      end else begin
        if (frameIdx_q == 3'd0) begin
          dirDown_d  = 1'b0;
          frameIdx_d = 3'd1;
        end else begin
          frameIdx_d = frameIdx_q - 3'd1;
        end
      end
`else
      frameIdx_d = (frameIdx_q >= lastIdx) ? 3'd0 : frameIdx_q + 3'd1;
`endif
    end
  end

  // Frame FSM; a tick arriving mid-frame is remembered once so refreshes are not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ESPERA;
      pending_q   <= 1'b0;
      txValid_q   <= 1'b0;
      byteCnt_q   <= '0;
      estOut_q    <= EST_IDLE;
      frameIdx_q  <= '0;
      animCnt_q   <= '0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      dirDown_q   <= 1'b0;
`endif
    end else begin
      frameDone_q <= 1'b0;
      if (state_q != ESPERA && tick) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        ESPERA: begin
          if (enable && (tick || pending_q)) begin
            estOut_q  <= estado_in;
            byteCnt_q <= '0;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
            state_q   <= BUSCA;
            if (estado_in != estOut_q) begin
              frameIdx_q <= '0;
              animCnt_q  <= '0;
`ifdef SEQ_PINGPONG_EN
              dirDown_q  <= 1'b0;
`endif
            end
          end
        end
        BUSCA: begin
          txValid_q <= 1'b1;
          state_q   <= ENVIA;
        end
        ENVIA: begin
          if (tx_ready) begin
            txValid_q <= 1'b0;
            if (byteCnt_q == LAST_BYTE) begin
              state_q <= FIM;
            end else begin
              byteCnt_q <= byteCnt_q + 10'd1;
              state_q   <= BUSCA;
            end
          end
        end
        FIM: begin
          frameDone_q <= 1'b1;
          byteCnt_q   <= '0;
          busy_q      <= 1'b0;
          frameIdx_q  <= frameIdx_d;
          animCnt_q   <= animCnt_d;
`ifdef SEQ_PINGPONG_EN
          dirDown_q   <= dirDown_d;
`endif
          state_q     <= ESPERA;
        end
        default: state_q <= ESPERA;
      endcase
    end
  end

  assign tx_valid     = txValid_q;
  assign byte_counter = byteCnt_q;
  assign estado_out   = estOut_q;
  assign frame_idx    = frameIdx_q;
  assign frame_done   = frameDone_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sequenciador_quadros.sv
// Self-checking bench for sequenciador_quadros: a behavioural frame/animation
// model compared every cycle, plus literal timing and frame-index sequences.
module tb_sequenciador_quadros;

  localparam int TICK  = 16;
  localparam int ANIM  = 1;
  localparam int ANIM2 = 3;

  localparam logic [3:0] IDLE  = 4'b0000;
  localparam logic [3:0] DORM  = 4'b0001;
  localparam logic [3:0] AULA  = 4'b0100;
  localparam logic [3:0] MORTO = 4'b1000;

  logic       clk = 1'b0;
  logic       rst, enable, txReady;
  logic [3:0] estadoIn;

  logic       txValid, frameDone, busy;
  logic [9:0] byteCounter;
  logic [3:0] estadoOut;
  logic [2:0] frameIdx;

  logic       txValid2, frameDone2, busy2;
  logic [9:0] byteCounter2;
  logic [3:0] estadoOut2;
  logic [2:0] frameIdx2;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;
  bit modelOn = 1'b0;

  always #5 clk = ~clk;

  sequenciador_quadros #(.TICK_DIV(TICK), .ANIM_DIV(ANIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .estado_in    (estadoIn),
    .tx_ready     (txReady),
    .tx_valid     (txValid),
    .byte_counter (byteCounter),
    .estado_out   (estadoOut),
    .frame_idx    (frameIdx),
    .frame_done   (frameDone),
    .busy         (busy)
  );

  sequenciador_quadros #(.TICK_DIV(TICK), .ANIM_DIV(ANIM2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .estado_in    (estadoIn),
    .tx_ready     (txReady),
    .tx_valid     (txValid2),
    .byte_counter (byteCounter2),
    .estado_out   (estadoOut2),
    .frame_idx    (frameIdx2),
    .frame_done   (frameDone2),
    .busy         (busy2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      if (errors >= 100) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input logic [3:0] est, input bit rdy);
    rst      = r;
    enable   = en;
    estadoIn = est;
    txReady  = rdy;
  endtask

  function automatic int nFrames(input logic [3:0] est);
    case (est)
      DORM:    return 4;
      4'b0010: return 5;
      AULA:    return 7;
      MORTO:   return 8;
      default: return 6;
    endcase
  endfunction

  // Frame index shown after k completed frames since the last state change.
  function automatic logic [2:0] expIdx(input int k, input int adiv, input logic [3:0] est);
    int n, step, per, p;
    n    = nFrames(est);
    step = k / adiv;
`ifdef SEQ_PINGPONG_EN
    if (n == 1) return 3'd0;
    per = 2 * n - 2;
    p   = step % per;
    return 3'((p < n) ? p : per - p);
`else
    per = 0;
    p   = 0;
    return 3'(step % n);
`endif
  endfunction

  // Behavioural model: refresh pacing, byte handshake and completed-frame count.
  int         mTickCnt, mByte, mFrames;
  bit         mPend, mBusy, mValid, mFetch, mLast, mDone, tickNow;
  logic [3:0] mEst;

  always @(posedge clk) begin
    edgeCnt++;
    if (rst) begin
      mTickCnt = 0; mByte = 0; mFrames = 0; mEst = IDLE;
      mPend = 0; mBusy = 0; mValid = 0; mFetch = 0; mLast = 0; mDone = 0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      tickNow  = (mTickCnt == TICK - 1);
      mTickCnt = (mTickCnt + 1) % TICK;
      mDone    = 0;
      if (!mBusy) begin
        if (enable && (tickNow || mPend)) begin
          if (estadoIn != mEst) mFrames = 0;
          mEst = estadoIn; mBusy = 1; mByte = 0; mValid = 0; mFetch = 1; mPend = 0;
        end
      end else begin
        if (tickNow) mPend = 1;
        if (mLast) begin
          mLast = 0; mBusy = 0; mDone = 1; mByte = 0; mFrames++;
        end else if (mFetch) begin
          mFetch = 0; mValid = 1;
        end else if (txReady) begin
          mValid = 0;
          if (mByte == 1023) mLast = 1;
          else begin mByte++; mFetch = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("tx_valid", 32'(txValid), 32'(mValid));
      checkOutput("byte_counter", 32'(byteCounter), 32'(mByte));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("frame_done", 32'(frameDone), 32'(mDone));
      checkOutput("estado_out", 32'(estadoOut), 32'(mEst));
      checkOutput("frame_idx", 32'(frameIdx), 32'(expIdx(mFrames, ANIM, mEst)));
      checkOutput("frame_idx_div3", 32'(frameIdx2), 32'(expIdx(mFrames, ANIM2, mEst)));
    end
  end

  // sel: 0 byte_counter, 1 busy, 2 frame_done
  task automatic waitFor(input string what, input int sel, input int value, input int limit);
    bit hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (byteCounter == 10'(value));
        1:       hit = (busy == 1'(value));
        default: hit = (frameDone == 1'(value));
      endcase
    end
    if (!hit) checkOutput({what, " timeout"}, 0, 1);
  endtask

  int relEdge, startEdge;
  logic [2:0] seqA[8], seqA2[8], seqD[8], seqD2[8];
  logic [2:0] expAula[8], expDorm[8], expDiv3[8];

  initial begin
`ifdef SEQ_PINGPONG_EN
    expAula = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5};
    expDorm = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
`else
    expAula = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    expDorm = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
`endif
    expDiv3 = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};

    applyStimulus(1, 0, IDLE, 1);
    repeat (3) @(negedge clk);
    checkOutput("reset tx_valid", 32'(txValid), 0);
    checkOutput("reset byte_counter", 32'(byteCounter), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset frame_done", 32'(frameDone), 0);
    checkOutput("reset frame_idx", 32'(frameIdx), 0);
    checkOutput("reset estado_out", 32'(estadoOut), 0);

    // First frame starts on the first tick and takes 2049 cycles to frame_done.
    relEdge = edgeCnt;
    applyStimulus(0, 1, IDLE, 1);
    waitFor("first start", 1, 1, 100);
    checkOutput("first start edge", 32'(edgeCnt - relEdge), 16);
    startEdge = edgeCnt;
    waitFor("byte 1023", 0, 1023, 3000);
    waitFor("first frame_done", 2, 1, 100);
    checkOutput("frame_done latency", 32'(edgeCnt - startEdge), 2049);
    checkOutput("byte_counter after frame", 32'(byteCounter), 0);
    @(negedge clk);
    checkOutput("pending restart busy", 32'(busy), 1);

    // Backpressure at byte 100.
    waitFor("byte 100", 0, 100, 3000);
    applyStimulus(0, 1, IDLE, 0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold byte", 32'(byteCounter), 100);
      checkOutput("hold tx_valid", 32'(txValid), 1);
    end
    applyStimulus(0, 1, IDLE, 1);
    @(negedge clk);
    checkOutput("after accept byte", 32'(byteCounter), 101);
    checkOutput("after accept tx_valid", 32'(txValid), 0);
    @(negedge clk);
    checkOutput("next offer tx_valid", 32'(txValid), 1);
    applyStimulus(0, 1, AULA, 1);
    waitFor("frame2 done", 2, 1, 3000);

    // Eight DANDO_AULA frames.
    for (int f = 0; f < 8; f++) begin
      waitFor("aula mid", 0, 512, 3000);
      seqA[f]  = frameIdx;
      seqA2[f] = frameIdx2;
      checkOutput("aula estado_out", 32'(estadoOut), 32'(AULA));
      waitFor("aula done", 2, 1, 3000);
    end
    applyStimulus(0, 1, IDLE, 1);
    for (int f = 0; f < 8; f++) begin
      checkOutput($sformatf("aula seq[%0d]", f), 32'(seqA[f]), 32'(expAula[f]));
      checkOutput($sformatf("aula div3 seq[%0d]", f), 32'(seqA2[f]), 32'(expDiv3[f]));
    end

    // State change mid-frame is ignored until the next frame start.
    waitFor("idle byte 500", 0, 500, 3000);
    applyStimulus(0, 1, MORTO, 1);
    repeat (3) @(negedge clk);
    checkOutput("mid-frame estado_out", 32'(estadoOut), 32'(IDLE));
    checkOutput("idle frame_idx", 32'(frameIdx), 0);
    waitFor("idle done", 2, 1, 3000);
    checkOutput("estado_out at done", 32'(estadoOut), 32'(IDLE));
    waitFor("morto byte 10", 0, 10, 100);
    checkOutput("morto estado_out", 32'(estadoOut), 32'(MORTO));
    checkOutput("morto frame_idx", 32'(frameIdx), 0);

    // Reset mid-frame.
    waitFor("morto byte 300", 0, 300, 3000);
    applyStimulus(1, 1, MORTO, 1);
    @(negedge clk);
    checkOutput("rst tx_valid", 32'(txValid), 0);
    checkOutput("rst byte_counter", 32'(byteCounter), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst frame_done", 32'(frameDone), 0);
    checkOutput("rst estado_out", 32'(estadoOut), 0);
    applyStimulus(0, 1, MORTO, 1);
    waitFor("restart", 1, 1, 100);

    // Enable dropped mid-frame: frame completes, pending frame waits for enable.
    waitFor("byte 200", 0, 200, 3000);
    applyStimulus(0, 0, MORTO, 1);
    waitFor("disabled done", 2, 1, 3000);
    repeat (40) @(negedge clk);
    checkOutput("no start while disabled", 32'(busy), 0);
    applyStimulus(0, 1, DORM, 1);
    @(negedge clk);
    checkOutput("pending start busy", 32'(busy), 1);
    checkOutput("pending start estado_out", 32'(estadoOut), 32'(DORM));

    // Eight DORMINDO frames.
    for (int f = 0; f < 8; f++) begin
      waitFor("dorm mid", 0, 512, 3000);
      seqD[f]  = frameIdx;
      seqD2[f] = frameIdx2;
      waitFor("dorm done", 2, 1, 3000);
    end
    for (int f = 0; f < 8; f++) begin
      checkOutput($sformatf("dorm seq[%0d]", f), 32'(seqD[f]), 32'(expDorm[f]));
      checkOutput($sformatf("dorm div3 seq[%0d]", f), 32'(seqD2[f]), 32'(expDiv3[f]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
